// File: rtl/nand_cmd_sequencer.sv
// nand_cmd_sequencer
// Command source for the NAND flash controller. It turns start_w/start_r/start_e
// requests into 32-bit flash commands ({opcode, row}) with a one-cycle start_cmd
// strobe. It keeps separate write, read and erase row counters and waits for the
// controller's completion, a flash error or a timeout before issuing again.

module nand_cmd_sequencer #(
    parameter int unsigned PAGE_BITS   = 6,
    parameter logic [23:0] ROW_MAX     = 24'h01FFFF,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_w,
    input  logic        start_r,
    input  logic        start_e,
    input  logic        end_write,
    input  logic        end_read,
    input  logic        end_erase,
    input  logic        flash_err,
    output logic [31:0] cmd,
    output logic        start_cmd,
    output logic        busy,
    output logic [1:0]  seq_state,
    output logic        err_timeout,
    output logic        err_flash,
    output logic [23:0] wr_row,
    output logic [23:0] rd_row,
    output logic [23:0] er_row
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_ERASE = 2'd3
    } op_t;

    localparam logic [7:0]  OPC_WRITE = 8'h01;
    localparam logic [7:0]  OPC_READ  = 8'h02;
    localparam logic [7:0]  OPC_ERASE = 8'h03;
    localparam logic [23:0] ER_STEP   = 24'd1 << PAGE_BITS;
    localparam logic [23:0] TMO_LAST  = TIMEOUT_CYC - 24'd1;

    state_t      state;
    state_t      state_next;
    op_t         cur_op;
    op_t         sel_op;
    logic [31:0] sel_cmd;

    // Three-stage shift per request line: [0] and [1] synchronise, [2] holds
    // the previous synchronised level for the rising-edge detector.
    logic [2:0]  sync_w;
    logic [2:0]  sync_r;
    logic [2:0]  sync_e;
    logic        edge_w;
    logic        edge_r;
    logic        edge_e;

    logic        pend_w;
    logic        pend_r;
    logic        pend_e;
    logic        take_w;
    logic        take_r;
    logic        take_e;

    logic [23:0] tmo_cnt;
    logic        tmo_hit;
    logic        done_ok;
    logic        fault;

    logic [23:0] wr_row_nxt;
    logic [23:0] rd_row_nxt;
    logic [24:0] er_sum;
    logic [23:0] er_row_nxt;

    // Synchronise the asynchronous request levels into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_w <= '0;
            sync_r <= '0;
            sync_e <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the value from before this edge, which is what
            // makes the shift register shift instead of collapsing.
            sync_w <= {sync_w[1:0], start_w};
            sync_r <= {sync_r[1:0], start_r};
            sync_e <= {sync_e[1:0], start_e};
        end
    end

    assign edge_w = sync_w[1] & ~sync_w[2];
    assign edge_r = sync_r[1] & ~sync_r[2];
    assign edge_e = sync_e[1] & ~sync_e[2];

    // Pending flags: one request per type is remembered; a fresh edge wins
    // over the clear so a request landing on the issue cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_w <= 1'b0;
            pend_r <= 1'b0;
            pend_e <= 1'b0;
        end else begin
            pend_w <= (pend_w & ~take_w) | edge_w;
            pend_r <= (pend_r & ~take_r) | edge_r;
            pend_e <= (pend_e & ~take_e) | edge_e;
        end
    end

    // Choose the next command from the pending flags: erase > write > read.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_op  = OP_NONE;
        sel_cmd = cmd;
        take_w  = 1'b0;
        take_r  = 1'b0;
        take_e  = 1'b0;
        if (state == S_IDLE) begin
            if (pend_e) begin
                sel_op  = OP_ERASE;
                sel_cmd = {OPC_ERASE, er_row};
                take_e  = 1'b1;
            end else if (pend_w) begin
                sel_op  = OP_WRITE;
                sel_cmd = {OPC_WRITE, wr_row};
                take_w  = 1'b1;
            end else if (pend_r) begin
                sel_op  = OP_READ;
                sel_cmd = {OPC_READ, rd_row};
                take_r  = 1'b1;
            end
        end
    end

    // Completion decode while waiting: flash_err beats a matching end, and a
    // timeout only counts when neither arrived on that cycle.
    always_comb begin
        fault   = 1'b0;
        done_ok = 1'b0;
        tmo_hit = 1'b0;
        if (state == S_WAIT) begin
            fault = flash_err;
            if (!flash_err) begin
                unique case (cur_op)
                    OP_WRITE: done_ok = end_write;
                    OP_READ:  done_ok = end_read;
                    OP_ERASE: done_ok = end_erase;
                    default:  done_ok = 1'b0;
                endcase
                tmo_hit = !done_ok && (tmo_cnt == TMO_LAST);
            end
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> IDLE loop.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (sel_op != OP_NONE) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (fault || done_ok || tmo_hit) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Latch the chosen command and remember its type for completion matching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd    <= '0;
            cur_op <= OP_NONE;
        end else if (sel_op != OP_NONE) begin
            cmd    <= sel_cmd;
            cur_op <= sel_op;
        end
    end

    // Timeout counter: cleared on issue, counts in WAIT, holds at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT && tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 24'd1;
        end
    end

    // Row increments with wrap to 0 past ROW_MAX; the erase sum is one bit
    // wider so a step past the top of the 24-bit space still compares right.
    always_comb begin
        wr_row_nxt = (wr_row >= ROW_MAX) ? 24'd0 : wr_row + 24'd1;
        rd_row_nxt = (rd_row >= ROW_MAX) ? 24'd0 : rd_row + 24'd1;
        er_sum     = {1'b0, er_row} + {1'b0, ER_STEP};
        er_row_nxt = (er_sum > {1'b0, ROW_MAX}) ? 24'd0 : er_sum[23:0];
    end

    // Advance only the counter of the operation that completed cleanly;
    // faults and timeouts leave the row in place so it is retried.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_row <= '0;
            rd_row <= '0;
            er_row <= '0;
        end else if (done_ok) begin
            unique case (cur_op)
                OP_WRITE: wr_row <= wr_row_nxt;
                OP_READ:  rd_row <= rd_row_nxt;
                OP_ERASE: er_row <= er_row_nxt;
                default:  ;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_flash   <= 1'b0;
        end else begin
            if (tmo_hit) err_timeout <= 1'b1;
            if (fault)   err_flash   <= 1'b1;
        end
    end

    assign start_cmd = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign seq_state = state;

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// tb_nand_cmd_sequencer
// Directed bench for nand_cmd_sequencer. Two instances share all inputs:
// dut_a uses the default row range, dut_b uses ROW_MAX=3 and PAGE_BITS=1 so the
// wrap boundaries are reachable in a few commands. Both use a 100-cycle timeout.

module tb_nand_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        start_w;
    logic        start_r;
    logic        start_e;
    logic        end_write;
    logic        end_read;
    logic        end_erase;
    logic        flash_err;

    logic [31:0] cmd_a;
    logic        start_cmd_a;
    logic        busy_a;
    logic [1:0]  seq_state_a;
    logic        err_timeout_a;
    logic        err_flash_a;
    logic [23:0] wr_row_a;
    logic [23:0] rd_row_a;
    logic [23:0] er_row_a;

    logic [31:0] cmd_b;
    logic        start_cmd_b;
    logic        busy_b;
    logic [1:0]  seq_state_b;
    logic        err_timeout_b;
    logic        err_flash_b;
    logic [23:0] wr_row_b;
    logic [23:0] rd_row_b;
    logic [23:0] er_row_b;

    int total = 0;
    int bad   = 0;

    nand_cmd_sequencer #(
        .PAGE_BITS  (6),
        .ROW_MAX    (24'h01FFFF),
        .TIMEOUT_CYC(24'd100)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start_w    (start_w),
        .start_r    (start_r),
        .start_e    (start_e),
        .end_write  (end_write),
        .end_read   (end_read),
        .end_erase  (end_erase),
        .flash_err  (flash_err),
        .cmd        (cmd_a),
        .start_cmd  (start_cmd_a),
        .busy       (busy_a),
        .seq_state  (seq_state_a),
        .err_timeout(err_timeout_a),
        .err_flash  (err_flash_a),
        .wr_row     (wr_row_a),
        .rd_row     (rd_row_a),
        .er_row     (er_row_a)
    );

    nand_cmd_sequencer #(
        .PAGE_BITS  (1),
        .ROW_MAX    (24'd3),
        .TIMEOUT_CYC(24'd100)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start_w    (start_w),
        .start_r    (start_r),
        .start_e    (start_e),
        .end_write  (end_write),
        .end_read   (end_read),
        .end_erase  (end_erase),
        .flash_err  (flash_err),
        .cmd        (cmd_b),
        .start_cmd  (start_cmd_b),
        .busy       (busy_b),
        .seq_state  (seq_state_b),
        .err_timeout(err_timeout_b),
        .err_flash  (err_flash_b),
        .wr_row     (wr_row_b),
        .rd_row     (rd_row_b),
        .er_row     (er_row_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and land 1 time unit after the last rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start_w   = 1'b0;
        start_r   = 1'b0;
        start_e   = 1'b0;
        end_write = 1'b0;
        end_read  = 1'b0;
        end_erase = 1'b0;
        flash_err = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    // Raise the selected request levels for 3 clocks, then drop them.
    task automatic req(input logic w, input logic r, input logic e);
        start_w = w;
        start_r = r;
        start_e = e;
        tick(3);
        start_w = 1'b0;
        start_r = 1'b0;
        start_e = 1'b0;
    endtask

    // One-cycle completion / fault pulses from the controller.
    task automatic done(input logic w, input logic r, input logic e, input logic fe);
        end_write = w;
        end_read  = r;
        end_erase = e;
        flash_err = fe;
        tick(1);
        end_write = 1'b0;
        end_read  = 1'b0;
        end_erase = 1'b0;
        flash_err = 1'b0;
    endtask

    // Wait (bounded) for the start_cmd strobe of dut_a.
    task automatic wait_start(input string tag);
        int n = 0;
        while (start_cmd_a !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check(tag, 32'(start_cmd_a), 32'd1);
    endtask

    initial begin
        int pulses;

        // ---- 1: reset values, then a single write ----
        do_reset();
        check("rst_cmd",       cmd_a, 32'h0);
        check("rst_start_cmd", 32'(start_cmd_a), 32'd0);
        check("rst_busy",      32'(busy_a), 32'd0);
        check("rst_state",     32'(seq_state_a), 32'd0);
        check("rst_errs",      32'({err_timeout_a, err_flash_a}), 32'd0);
        check("rst_rows",      32'(wr_row_a | rd_row_a | er_row_a), 32'd0);

        req(1'b1, 1'b0, 1'b0);
        wait_start("t1_start");
        check("t1_cmd",   cmd_a, 32'h0100_0000);
        check("t1_busy",  32'(busy_a), 32'd1);
        check("t1_state", 32'(seq_state_a), 32'd1);
        tick(1);
        check("t1_strobe_once", 32'(start_cmd_a), 32'd0);
        check("t1_wait_state",  32'(seq_state_a), 32'd2);
        done(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_wr_row",  32'(wr_row_a), 32'd1);
        check("t1_busy_lo", 32'(busy_a), 32'd0);
        check("t1_idle",    32'(seq_state_a), 32'd0);

        // ---- 2: erase and write on the same cycle, erase first ----
        do_reset();
        req(1'b1, 1'b0, 1'b1);
        wait_start("t2_start_e");
        check("t2_cmd_e", cmd_a, 32'h0300_0000);
        tick(1);
        done(1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_er_row_a", 32'(er_row_a), 32'h40);
        check("t2_er_row_b", 32'(er_row_b), 32'h2);
        check("t2_gap_idle", 32'(start_cmd_a), 32'd0);
        tick(1);
        check("t2_gap_issue", 32'(start_cmd_a), 32'd1);
        check("t2_cmd_w",     cmd_a, 32'h0100_0000);
        tick(1);
        done(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_wr_row", 32'(wr_row_a), 32'd1);

        // ---- 3: read timeout after exactly 100 WAIT cycles ----
        do_reset();
        req(1'b0, 1'b1, 1'b0);
        wait_start("t3_start");
        check("t3_cmd", cmd_a, 32'h0200_0000);
        tick(1);
        tick(99);
        check("t3_still_wait", 32'(seq_state_a), 32'd2);
        check("t3_no_err_yet", 32'(err_timeout_a), 32'd0);
        tick(1);
        check("t3_idle",        32'(seq_state_a), 32'd0);
        check("t3_err_timeout", 32'(err_timeout_a), 32'd1);
        check("t3_rd_row_held", 32'(rd_row_a), 32'd0);
        req(1'b0, 1'b1, 1'b0);
        wait_start("t3_retry_start");
        check("t3_retry_cmd", cmd_a, 32'h0200_0000);
        tick(1);
        done(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_rd_row",     32'(rd_row_a), 32'd1);
        check("t3_err_sticky", 32'(err_timeout_a), 32'd1);

        // ---- 4: wrap of wr_row and er_row on dut_b (ROW_MAX=3) ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, 1'b0);
            wait_start("t4_start_w");
            check("t4_cmd_b", cmd_b, {8'h01, 24'(i)});
            tick(1);
            done(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("t4_wr_wrap_b", 32'(wr_row_b), 32'd0);
        check("t4_wr_row_a",  32'(wr_row_a), 32'd4);
        for (int i = 0; i < 2; i++) begin
            req(1'b0, 1'b0, 1'b1);
            wait_start("t4_start_e");
            check("t4_cmd_e_b", cmd_b, {8'h03, 24'(2 * i)});
            tick(1);
            done(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("t4_er_wrap_b", 32'(er_row_b), 32'd0);
        check("t4_er_row_a",  32'(er_row_a), 32'h80);

        // ---- 5: ignored mismatched end, then flash_err beats end_read ----
        do_reset();
        req(1'b0, 1'b1, 1'b0);
        wait_start("t5_start");
        tick(1);
        done(1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_mismatch_wait", 32'(seq_state_a), 32'd2);
        check("t5_mismatch_rows", 32'(wr_row_a | er_row_a), 32'd0);
        done(1'b0, 1'b1, 1'b0, 1'b1);
        check("t5_err_flash",  32'(err_flash_a), 32'd1);
        check("t5_rd_row",     32'(rd_row_a), 32'd0);
        check("t5_idle",       32'(seq_state_a), 32'd0);
        check("t5_no_timeout", 32'(err_timeout_a), 32'd0);

        // ---- 6: pending depth 1, then reset in the middle of WAIT ----
        do_reset();
        req(1'b1, 1'b0, 1'b0);
        wait_start("t6_start");
        tick(1);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, 1'b0);
            tick(3);
        end
        check("t6_still_wait", 32'(seq_state_a), 32'd2);
        done(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_wr_row1", 32'(wr_row_a), 32'd1);
        tick(1);
        check("t6_extra_issue", 32'(start_cmd_a), 32'd1);
        check("t6_extra_cmd",   cmd_a, 32'h0100_0001);
        tick(1);
        done(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_wr_row2", 32'(wr_row_a), 32'd2);
        pulses = 0;
        repeat (10) begin
            tick(1);
            if (start_cmd_a === 1'b1) pulses++;
        end
        check("t6_no_third", 32'(pulses), 32'd0);

        req(1'b1, 1'b0, 1'b0);
        wait_start("t6_pre_rst_start");
        tick(1);
        check("t6_pre_rst_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #2;
        check("t6_rst_cmd",   cmd_a, 32'h0);
        check("t6_rst_busy",  32'(busy_a), 32'd0);
        check("t6_rst_state", 32'(seq_state_a), 32'd0);
        check("t6_rst_start", 32'(start_cmd_a), 32'd0);
        check("t6_rst_wr",    32'(wr_row_a), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(5);
        check("t6_post_rst_idle", 32'(seq_state_a), 32'd0);
        check("t6_post_rst_cmd",  cmd_a, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
